// File: rtl/pwm_peripheral_mc.sv
// Multi-channel PWM generator: shared prescaled timebase, edge/center-aligned counting,
// per-channel duty with shadow registers committed at period boundaries.
module pwm_peripheral_mc #(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 8,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               center_mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic               duty_we,
    input  logic [CH_W-1:0]    duty_ch,
    input  logic [CNT_W-1:0]   duty_val,
    output logic [NUM_CH-1:0]  out,
    output logic               period_start
);

    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] prescale_act;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   period_act;
    logic               dir_down;
    logic               mode_act;
    logic [CNT_W-1:0]   duty_pend [NUM_CH];
    logic [CNT_W-1:0]   duty_act  [NUM_CH];

    logic               tick;
    logic               boundary;
    logic               load;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               dir_nxt;

    assign tick = (presc_cnt == prescale_act);
    assign load = !enable || boundary;

    // Next counter value and direction; boundary marks the tick where cnt returns to 0
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir_down;
        boundary = 1'b0;
        if (enable && tick) begin
            if (period_act == '0) begin
                cnt_nxt  = '0;
                dir_nxt  = 1'b0;
                boundary = 1'b1;
            end else if (!mode_act) begin
                if (cnt == period_act) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end else if (!dir_down) begin
                if (cnt == period_act) begin
                    // With TOP=1 the turn-around step already lands on 0
                    if (period_act == CNT_W'(1)) begin
                        cnt_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                        dir_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end else begin
                if (cnt == CNT_W'(1)) begin
                    cnt_nxt  = '0;
                    dir_nxt  = 1'b0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
        end
    end

    // Timebase: prescaler, counter, direction and boundary pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir_down     <= 1'b0;
            period_start <= 1'b0;
        end else if (!enable) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir_down     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            presc_cnt    <= tick ? '0 : presc_cnt + PRESC_W'(1);
            cnt          <= cnt_nxt;
            dir_down     <= dir_nxt;
            period_start <= boundary;
        end
    end

    // Active configuration shadows: transparent while disabled, else loaded at boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act   <= '0;
            prescale_act <= '0;
            mode_act     <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                duty_act[i] <= '0;
            end
        end else if (load) begin
            period_act   <= period;
            prescale_act <= prescale;
            mode_act     <= center_mode;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                duty_act[i] <= duty_pend[i];
            end
        end
    end

    // Pending duty registers written from the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                duty_pend[i] <= '0;
            end
        end else if (duty_we && (32'(duty_ch) < NUM_CH)) begin
            duty_pend[duty_ch] <= duty_val;
        end
    end

    // Output stage: compare against current count, then gate by enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                out[i] <= en_out[i] & (~en_pwm[i] | (cnt < duty_act[i]));
            end
        end
    end

endmodule

// File: tb/tb_pwm_peripheral_mc.sv
// Directed + randomized bench for pwm_peripheral_mc against a phase-based reference model.
module tb_pwm_peripheral_mc;

    localparam int unsigned NCH = 12;
    localparam int unsigned CW  = 8;
    localparam int unsigned PW  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           center_mode;
    logic [CW-1:0]  period;
    logic [PW-1:0]  prescale;
    logic [NCH-1:0] en_out;
    logic [NCH-1:0] en_pwm;
    logic           duty_we;
    logic [3:0]     duty_ch;
    logic [CW-1:0]  duty_val;
    logic [NCH-1:0] out;
    logic           period_start;

    pwm_peripheral_mc #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .center_mode(center_mode),
        .period(period), .prescale(prescale), .en_out(en_out), .en_pwm(en_pwm),
        .duty_we(duty_we), .duty_ch(duty_ch), .duty_val(duty_val),
        .out(out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: position inside the period measured in ticks
    int             m_p, m_ps, m_pc, m_phase;
    bit             m_mode;
    int             m_act  [NCH];
    int             m_pend [NCH];
    logic [NCH-1:0] exp_out;
    logic           exp_ps;
    int             ones [NCH];
    int             ps_seen;

    function automatic int m_len();
        if (m_p == 0) return 1;
        return m_mode ? 2 * m_p : m_p + 1;
    endfunction

    function automatic int m_cnt();
        if (!m_mode || m_phase <= m_p) return m_phase;
        return 2 * m_p - m_phase;
    endfunction

    task automatic model_reset();
        m_p = 0; m_ps = 0; m_pc = 0; m_phase = 0; m_mode = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            m_act[i] = 0;
            m_pend[i] = 0;
        end
        exp_out = '0;
        exp_ps  = 1'b0;
    endtask

    task automatic model_step();
        logic [NCH-1:0] o;
        bit bnd;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < int'(NCH); i++)
            o[i] = en_out[i] && (!en_pwm[i] || (m_cnt() < m_act[i]));
        bnd = 1'b0;
        if (!enable) begin
            m_pc = 0;
            m_phase = 0;
        end else if (m_pc == m_ps) begin
            m_pc = 0;
            m_phase++;
            if (m_phase >= m_len()) begin
                m_phase = 0;
                bnd = 1'b1;
            end
        end else begin
            m_pc++;
        end
        if (!enable || bnd) begin
            m_p = int'(period);
            m_ps = int'(prescale);
            m_mode = center_mode;
            for (int i = 0; i < int'(NCH); i++) m_act[i] = m_pend[i];
        end
        if (duty_we && (int'(duty_ch) < int'(NCH))) m_pend[duty_ch] = int'(duty_val);
        exp_out = o;
        exp_ps  = enable && bnd;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("out", 32'(out), 32'(exp_out));
        chk("period_start", 32'(period_start), 32'(exp_ps));
        chk("cnt", 32'(dut.cnt), 32'(m_cnt()));
    endtask

    task automatic write_duty(input int ch, input int val);
        duty_ch  = 4'(ch);
        duty_val = CW'(val);
        duty_we  = 1'b1;
        cycle();
        duty_we  = 1'b0;
    endtask

    task automatic count_win(input int n);
        for (int i = 0; i < int'(NCH); i++) ones[i] = 0;
        ps_seen = 0;
        repeat (n) begin
            cycle();
            for (int i = 0; i < int'(NCH); i++) ones[i] += int'(out[i]);
            ps_seen += int'(period_start);
        end
    endtask

    task automatic wait_cnt(input int v);
        int g = 0;
        while (m_cnt() != v && g < 200) begin
            cycle();
            g++;
        end
        chk("wait_cnt_timeout", 32'(g < 200), 32'(1));
    endtask

    task automatic wait_model_ps();
        int g = 0;
        do begin
            cycle();
            g++;
        end while (!exp_ps && g < 200);
        chk("wait_ps_timeout", 32'(g < 200), 32'(1));
    endtask

    task automatic gap(output int g);
        g = 0;
        do begin
            cycle();
            g++;
        end while (!period_start && g < 200);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out", 32'(out), 32'(0));
        chk("rst_period_start", 32'(period_start), 32'(0));
        chk("rst_cnt", 32'(dut.cnt), 32'(0));
    endtask

    initial begin
        int g;
        rst_n = 1'b0; enable = 1'b0; center_mode = 1'b0;
        period = '0; prescale = '0; en_out = '0; en_pwm = '0;
        duty_we = 1'b0; duty_ch = '0; duty_val = '0;
        model_reset();
        #2;
        chk("reset_out", 32'(out), 32'(0));
        chk("reset_period_start", 32'(period_start), 32'(0));
        cycle();
        cycle();
        rst_n = 1'b1;

        // 1: edge-aligned, period 9, duty 3
        period = CW'(9); prescale = '0; en_out = '1; en_pwm = '1;
        write_duty(0, 3);
        cycle();
        enable = 1'b1;
        count_win(10);
        count_win(10);
        chk("t1_high", 32'(ones[0]), 32'(3));
        chk("t1_ps", 32'(ps_seen), 32'(1));

        // 2: center-aligned, period 4, prescale 3, duty 2
        enable = 1'b0; center_mode = 1'b1; period = CW'(4); prescale = PW'(3);
        write_duty(1, 2);
        cycle();
        enable = 1'b1;
        count_win(32);
        count_win(32);
        chk("t2_high", 32'(ones[1]), 32'(12));
        chk("t2_ps", 32'(ps_seen), 32'(1));

        // 3: duty update mid-period and exactly on the boundary
        enable = 1'b0; center_mode = 1'b0; period = CW'(9); prescale = '0;
        write_duty(2, 3);
        cycle();
        enable = 1'b1;
        count_win(10);
        wait_cnt(5);
        write_duty(2, 7);
        wait_model_ps();
        count_win(10);
        chk("t3_new_duty", 32'(ones[2]), 32'(7));
        wait_cnt(9);
        duty_ch = 4'd2; duty_val = CW'(1); duty_we = 1'b1;
        cycle();
        duty_we = 1'b0;
        chk("t3_bnd_pulse", 32'(period_start), 32'(1));
        count_win(10);
        chk("t3_bnd_old", 32'(ones[2]), 32'(7));
        count_win(10);
        chk("t3_bnd_new", 32'(ones[2]), 32'(1));

        // 4: duty extremes, static high, disabled output, invalid channel
        enable = 1'b0;
        write_duty(3, 0);
        write_duty(4, 10);
        write_duty(5, 2);
        write_duty(6, 5);
        en_pwm[5] = 1'b0;
        en_out[6] = 1'b0;
        cycle();
        enable = 1'b1;
        count_win(10);
        chk("t4_duty0", 32'(ones[3]), 32'(0));
        chk("t4_duty_over", 32'(ones[4]), 32'(10));
        chk("t4_static_high", 32'(ones[5]), 32'(10));
        chk("t4_out_off", 32'(ones[6]), 32'(0));
        write_duty(13, 0);
        write_duty(12, 9);
        count_win(25);
        count_win(10);
        chk("t4_inv_ch0", 32'(ones[0]), 32'(3));
        chk("t4_inv_ch3", 32'(ones[3]), 32'(0));
        en_pwm = '1; en_out = '1;

        // 5: period/mode change mid-period waits for boundary
        wait_cnt(4);
        period = CW'(4); center_mode = 1'b1;
        gap(g);
        gap(g);
        chk("t5_new_len", 32'(g), 32'(8));
        enable = 1'b0; center_mode = 1'b0; period = CW'(9);
        cycle();
        enable = 1'b1;
        wait_cnt(6);
        period = CW'(4); center_mode = 1'b1;
        gap(g);
        chk("t5_old_completes", 32'(g), 32'(4));
        gap(g);
        chk("t5_center_len", 32'(g), 32'(8));

        // 6: reset and enable drop mid-period
        wait_cnt(3);
        async_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        count_win(20);
        wait_cnt(2);
        enable = 1'b0;
        cycle();
        chk("t6_cnt_held", 32'(dut.cnt), 32'(0));
        period = CW'(6); center_mode = 1'b0;
        write_duty(0, 4);
        cycle();
        enable = 1'b1;
        gap(g);
        chk("t6_first_len", 32'(g), 32'(7));
        count_win(7);
        chk("t6_latest_duty", 32'(ones[0]), 32'(4));

        // Randomized traffic checked every cycle by the model
        for (int it = 0; it < 2000; it++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 60) begin
                period      = CW'($urandom_range(0, 12));
                prescale    = PW'($urandom_range(0, 3));
                center_mode = 1'($urandom_range(0, 1));
                en_out      = NCH'($urandom);
                en_pwm      = NCH'($urandom);
            end
            if (r >= 100 && r < 300) begin
                duty_ch  = 4'($urandom_range(0, 15));
                duty_val = CW'($urandom_range(0, 14));
                duty_we  = 1'b1;
            end
            if (r >= 990) enable = ~enable;
            if (r == 989) begin
                async_reset();
                cycle();
                rst_n = 1'b1;
            end
            cycle();
            duty_we = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
